counter_time_prog: RTL and testbench

//  Parametrised programmable period timer for the game timing path. Counts enable

---
 rtl/counter_time_prog_if.sv | 34 +++
 rtl/counter_time_prog.sv | 128 ++++++++++++
 tb/tb_counter_time_prog.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/counter_time_prog_if.sv
// Counter/timer bus: command inputs, load-time configuration and status outputs
// of the programmable period timer, grouped in one interface.
//   master : drives the commands (E, start, hold, abort) and the configuration
//            (mode_i, dir_i, limit_i); observes the status outputs.
//   slave  : the timer itself; receives the commands and configuration, drives
//            tempo, end_time, busy, done, err and laps.
interface counter_time_prog_if #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 4
);
  logic             E;
  logic             start;
  logic             hold;
  logic             abort;
  logic             mode_i;
  logic             dir_i;
  logic [WIDTH-1:0] limit_i;
  logic [WIDTH-1:0] tempo;
  logic             end_time;
  logic             busy;
  logic             done;
  logic             err;
  logic [LAP_W-1:0] laps;

  modport master (
    output E, start, hold, abort, mode_i, dir_i, limit_i,
    input  tempo, end_time, busy, done, err, laps
  );

  modport slave (
    input  E, start, hold, abort, mode_i, dir_i, limit_i,
    output tempo, end_time, busy, done, err, laps
  );
endinterface

// File: rtl/counter_time_prog.sv
// Programmable period timer. Counts E strobes up or down over a run-time period
// (limit_i strobes), pulsing end_time at the end of each period, in one-shot or
// periodic mode, with hold/resume, abort and a saturating lap counter.
// Ports:
//   CLK1 : system clock, rising edge
//   R    : synchronous active-low reset
//   bus  : counter_time_prog_if.slave (commands, configuration and status)
// The interface instance must be built with the same WIDTH/LAP_W as this module.
module counter_time_prog #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 4
) (
  input  logic                 CLK1,
  input  logic                 R,
  counter_time_prog_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tempo_q, tempo_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             end_q, end_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] init_cur, last_cur, init_load;

  // Restart value and terminal value for the captured configuration; the load
  // path needs the restart value of the incoming configuration instead.
  always_comb begin
    init_cur  = dir_q ? (limit_q - 1'b1) : '0;
    last_cur  = dir_q ? '0 : (limit_q - 1'b1);
    init_load = bus.dir_i ? (bus.limit_i - 1'b1) : '0;
  end

  always_comb begin
    state_d = state_q;
    tempo_d = tempo_q;
    limit_d = limit_q;
    laps_d  = laps_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    done_d  = done_q;
    end_d   = 1'b0;
    err_d   = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      tempo_d = '0;
      laps_d  = '0;
      done_d  = 1'b0;
    end else if (bus.start) begin
      if (state_q == S_HOLD) begin
        // Resume keeps the running configuration; limit_i is not looked at.
        state_d = S_RUN;
      end else if (bus.limit_i == '0) begin
        err_d = 1'b1;
      end else begin
        state_d = S_RUN;
        limit_d = bus.limit_i;
        mode_d  = bus.mode_i;
        dir_d   = bus.dir_i;
        tempo_d = init_load;
        laps_d  = '0;
        done_d  = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      if (bus.hold) begin
        state_d = S_HOLD;
      end else if (bus.E) begin
        if (tempo_q == last_cur) begin
          tempo_d = init_cur;
          end_d   = 1'b1;
          if (laps_q != '1) laps_d = laps_q + 1'b1;
          if (!mode_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (dir_q) begin
          tempo_d = tempo_q - 1'b1;
        end else begin
          tempo_d = tempo_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK1) begin
    if (!R) begin
      state_q <= S_IDLE;
      tempo_q <= '0;
      limit_q <= '0;
      laps_q  <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tempo_q <= tempo_d;
      limit_q <= limit_d;
      laps_q  <= laps_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      end_q   <= end_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.tempo    = tempo_q;
  assign bus.laps     = laps_q;
  assign bus.end_time = end_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_HOLD);

endmodule

// File: tb/tb_counter_time_prog.sv
module tb_counter_time_prog;
  localparam int WIDTH = 4;
  localparam int LAP_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  counter_time_prog_if #(.WIDTH(WIDTH), .LAP_W(LAP_W)) bus ();

  counter_time_prog #(.WIDTH(WIDTH), .LAP_W(LAP_W)) dut (
    .CLK1 (clk),
    .R    (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
  endtask

  // Drive one cycle of commands, let the edge happen, sample 1 time unit later.
  task automatic tick(input logic e, input logic st, input logic hd, input logic ab);
    bus.E     = e;
    bus.start = st;
    bus.hold  = hd;
    bus.abort = ab;
    @(posedge clk);
    #1;
    bus.E     = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic cfg(input logic md, input logic dr, input int lim);
    bus.mode_i  = md;
    bus.dir_i   = dr;
    bus.limit_i = lim[WIDTH-1:0];
  endtask

  initial begin
    bus.E = 0; bus.start = 0; bus.hold = 0; bus.abort = 0;
    cfg(0, 0, 0);

    // Reset state
    tick(0, 0, 0, 0);
    chk("rst_tempo", bus.tempo, 0);
    chk("rst_laps", bus.laps, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_end", bus.end_time, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;

    // 1. Reset mid-run
    cfg(1, 0, 9);
    tick(0, 1, 0, 0);
    chk("t1_busy_load", bus.busy, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
    chk("t1_tempo5", bus.tempo, 5);
    rst_n = 1'b0;
    tick(1, 0, 0, 0);
    rst_n = 1'b1;
    chk("t1_rst_tempo", bus.tempo, 0);
    chk("t1_rst_busy", bus.busy, 0);
    chk("t1_rst_laps", bus.laps, 0);
    chk("t1_rst_done", bus.done, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("t1_idle_tempo", bus.tempo, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // 2. Up periodic limit 9; E in the load cycle is ignored
    cfg(1, 0, 9);
    tick(1, 1, 0, 0);
    chk("t2_load_tempo", bus.tempo, 0);
    for (int i = 1; i <= 27; i++) begin
      tick(1, 0, 0, 0);
      chk("t2_tempo", bus.tempo, i % 9);
      chk("t2_end", bus.end_time, (i % 9 == 0) ? 1 : 0);
    end
    chk("t2_laps", bus.laps, 3);
    chk("t2_busy", bus.busy, 1);
    chk("t2_done", bus.done, 0);
    tick(0, 0, 0, 1);
    chk("t2_abort_laps", bus.laps, 0);
    chk("t2_abort_busy", bus.busy, 0);

    // 3. Down one-shot limit 5
    cfg(0, 1, 5);
    tick(0, 1, 0, 0);
    chk("t3_init", bus.tempo, 4);
    for (int i = 3; i >= 0; i--) begin
      tick(1, 0, 0, 0);
      chk("t3_tempo", bus.tempo, i);
      chk("t3_end_low", bus.end_time, 0);
    end
    tick(1, 0, 0, 0);
    chk("t3_end", bus.end_time, 1);
    chk("t3_wrap", bus.tempo, 4);
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_laps", bus.laps, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0);
    chk("t3_held_tempo", bus.tempo, 4);
    chk("t3_held_end", bus.end_time, 0);
    chk("t3_held_done", bus.done, 1);

    // 4. Hold / resume
    cfg(1, 0, 9);
    tick(0, 1, 0, 0);
    chk("t4_done_clr", bus.done, 0);
    chk("t4_laps_clr", bus.laps, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("t4_tempo3", bus.tempo, 3);
    tick(1, 0, 1, 0);
    chk("t4_hold", bus.tempo, 3);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
    chk("t4_hold_e", bus.tempo, 3);
    chk("t4_hold_busy", bus.busy, 1);
    cfg(0, 1, 0);
    tick(0, 1, 0, 0);
    chk("t4_resume_err", bus.err, 0);
    chk("t4_resume_tempo", bus.tempo, 3);
    tick(1, 0, 0, 0);
    chk("t4_after_resume", bus.tempo, 4);
    chk("t4_laps", bus.laps, 0);

    // 5. Errors / priority
    tick(0, 0, 0, 1);
    chk("t5_abort_tempo", bus.tempo, 0);
    cfg(1, 0, 0);
    tick(0, 1, 0, 0);
    chk("t5_err", bus.err, 1);
    chk("t5_err_busy", bus.busy, 0);
    tick(0, 0, 0, 0);
    chk("t5_err_pulse", bus.err, 0);
    cfg(1, 0, 9);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
    chk("t5_tempo6", bus.tempo, 6);
    tick(1, 1, 0, 0);
    chk("t5_restart", bus.tempo, 0);
    chk("t5_restart_busy", bus.busy, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t5_tempo2", bus.tempo, 2);
    tick(1, 1, 0, 1);
    chk("t5_abort_win_busy", bus.busy, 0);
    chk("t5_abort_win_tempo", bus.tempo, 0);
    chk("t5_abort_win_end", bus.end_time, 0);

    // 6. Lap saturation, limit 1 periodic
    cfg(1, 0, 1);
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1, 0, 0, 0);
      chk("t6_end", bus.end_time, 1);
      chk("t6_tempo", bus.tempo, 0);
      chk("t6_laps", bus.laps, (i > 3) ? 3 : i);
    end
    tick(0, 0, 0, 0);
    chk("t6_end_low", bus.end_time, 0);
    chk("t6_busy", bus.busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
